fifo_flow_ctrl_tx: RTL



---
 rtl/fifo_flow_ctrl_tx.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/fifo_flow_ctrl_tx.sv
// -----------------------------------------------------------------------------
// fifo_flow_ctrl_tx
//
// Multi-channel XON/XOFF flow-control byte generator for the UART TX path.
// Each of NCH receive-FIFO fill levels is tracked with hysteresis:
//   - at or above HI_MARK the channel enters XOFF,
//   - at or below LO_MARK it returns to XON,
//   - in between it keeps its state.
// Every state change marks the channel "dirty" (report pending).
// A round-robin arbiter picks one dirty channel per cycle while the TX FIFO
// is not full. It emits one byte reflecting the channel's state at grant time,
// so an XOFF followed by an XON that has not been sent yet coalesces into a
// single XON byte.
// With AGG_MODE=1 one aggregate report (8'hFF stop / 8'hFE start) follows the
// OR of all channel states instead.
//
// Optional feature, selected by the macro FLOW_KEEPALIVE_EN: a free-running
// counter with period KA_PERIOD marks every report dirty on wrap, so the full
// state is re-sent periodically.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   lvl        in   packed fill levels, channel ch at [ch*LVL_W +: LVL_W]
//   tx_full    in   UART TX FIFO full; no write is issued while high
//   msg        out  control byte, valid while wr is high
//   wr         out  single-cycle write strobe to the UART TX FIFO
//   xoff_state out  per-channel state, 1 = XOFF
//
// Handshake: wr is a one-cycle strobe. It is only raised for a grant that was
// made while tx_full was low at the preceding edge. There is no further
// acknowledge: the byte is considered accepted when wr is high.
// -----------------------------------------------------------------------------
module fifo_flow_ctrl_tx #(
    parameter int         NCH       = 4,
    parameter int         LVL_W     = 10,
    parameter int         HI_MARK   = 768,
    parameter int         LO_MARK   = 256,
    parameter logic [7:0] XOFF_BASE = 8'hF0,
    parameter logic [7:0] XON_BASE  = 8'hE0,
    parameter int         AGG_MODE  = 0,
    parameter int         KA_PERIOD = 1000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*LVL_W-1:0] lvl,
    input  logic                 tx_full,
    output logic [7:0]           msg,
    output logic                 wr,
    output logic [NCH-1:0]       xoff_state
);

    localparam int               PTR_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [LVL_W-1:0] HI_LVL = LVL_W'(HI_MARK);
    localparam logic [LVL_W-1:0] LO_LVL = LVL_W'(LO_MARK);

    logic [NCH-1:0]   r_st;
    logic [NCH-1:0]   r_dirty;
    logic             r_agg_dirty;
    logic [PTR_W-1:0] r_ptr;
    logic             r_wr;
    logic [7:0]       r_msg;

    logic [NCH-1:0]   w_st_next;
    logic [NCH-1:0]   w_trans;
    logic             w_agg_chg;
    logic [PTR_W:0]   w_scan;
    logic             w_found;
    logic [PTR_W-1:0] w_gnt_idx;
    logic             w_gnt;
    logic [NCH-1:0]   w_gnt_mask;
    logic [7:0]       w_code;
    logic [PTR_W-1:0] w_ptr_next;
    logic             w_ka_pulse;

    // Hysteresis per channel; w_trans flags a state change at this edge.
    always_comb begin
        w_st_next = r_st;
        w_trans   = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            if (!r_st[ch] && (lvl[ch*LVL_W +: LVL_W] >= HI_LVL)) begin
                w_st_next[ch] = 1'b1;
                w_trans[ch]   = 1'b1;
            end else if (r_st[ch] && (lvl[ch*LVL_W +: LVL_W] <= LO_LVL)) begin
                w_st_next[ch] = 1'b0;
                w_trans[ch]   = 1'b1;
            end
        end
        w_agg_chg = (|w_st_next) != (|r_st);
    end

    // Round-robin search: first dirty channel at or above the pointer, wrapping.
    always_comb begin
        w_scan    = '0;
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < NCH; k++) begin
            w_scan = {1'b0, r_ptr} + (PTR_W+1)'(k);
            if (w_scan >= (PTR_W+1)'(NCH)) begin
                w_scan = w_scan - (PTR_W+1)'(NCH);
            end
            if (!w_found && r_dirty[w_scan[PTR_W-1:0]]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_scan[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        w_gnt      = 1'b0;
        w_gnt_mask = '0;
        w_code     = 8'h00;
        w_ptr_next = r_ptr;
        if (AGG_MODE != 0) begin
            w_gnt  = !tx_full && r_agg_dirty;
            w_code = (|r_st) ? 8'hFF : 8'hFE;
        end else begin
            w_gnt = !tx_full && w_found;
            // The code reflects the state at the grant cycle, not the state
            // that originally made the channel dirty.
            w_code = r_st[w_gnt_idx] ? (XOFF_BASE + 8'(w_gnt_idx))
                                     : (XON_BASE  + 8'(w_gnt_idx));
            if (w_gnt) begin
                w_gnt_mask[w_gnt_idx] = 1'b1;
                w_ptr_next = (w_gnt_idx == PTR_W'(NCH-1)) ? '0 : w_gnt_idx + 1'b1;
            end
        end
    end

`ifdef FLOW_KEEPALIVE_EN
    localparam int KA_W = (KA_PERIOD > 1) ? $clog2(KA_PERIOD) : 1;

    logic [KA_W-1:0] r_ka_cnt;

    assign w_ka_pulse = (r_ka_cnt == KA_W'(KA_PERIOD - 1));

    // Runs regardless of tx_full; pending reports simply wait for space.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ka_cnt <= '0;
        end else if (w_ka_pulse) begin
            r_ka_cnt <= '0;
        end else begin
            r_ka_cnt <= r_ka_cnt + 1'b1;
        end
    end
`else
    assign w_ka_pulse = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st        <= '0;
            r_dirty     <= '0;
            r_agg_dirty <= 1'b0;
            r_ptr       <= '0;
            r_wr        <= 1'b0;
            r_msg       <= 8'h00;
        end else begin
            r_st <= w_st_next;
            if (AGG_MODE != 0) begin
                r_dirty     <= '0;
                r_agg_dirty <= (r_agg_dirty && !w_gnt) || w_agg_chg || w_ka_pulse;
            end else begin
                // A transition at the grant edge re-arms the bit, so a second byte follows.
                r_dirty     <= (r_dirty & ~w_gnt_mask) | w_trans | {NCH{w_ka_pulse}};
                r_agg_dirty <= 1'b0;
            end
            r_ptr <= w_ptr_next;
            r_wr  <= w_gnt;
            if (w_gnt) begin
                r_msg <= w_code;
            end
        end
    end

    assign wr         = r_wr;
    assign msg        = r_msg;
    assign xoff_state = r_st;

endmodule
